program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
- 32-bit program counter register for the single-cycle MIPS-style datapath.
- Captures the next-instruction address from the next-PC mux on each rising clock edge.
- Presents the registered PC to instruction memory and the PC+4 adder.
- Reports misaligned (non-word) addresses.

Parameters:
- WIDTH, 32, bit width of address and PC.
- RESET_VECTOR, 32'h00000000, PC value loaded on reset. Must be word-aligned.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Address  input  WIDTH  next PC value from the next-PC mux.
- PCResult  output  WIDTH  registered current PC.
- PCPlus4  output  WIDTH  combinational PCResult + 4.
- Misaligned  output  1  registered flag: the last loaded Address had Address[1:0] != 0.

Behaviour:
- One clock domain (Clk). Reset is synchronous and active-high; no asynchronous reset path.
- Rising edge with Reset=1: PCResult <= RESET_VECTOR, Misaligned <= 0. Address is ignored.
- Reset has priority over any load, including when asserted mid-run. Deassertion takes effect at the next edge.
- Rising edge with Reset=0, Address[1:0]==0: PCResult <= Address, Misaligned <= 0.
- Rising edge with Reset=0, Address[1:0]!=0: Misaligned <= 1. PCResult update depends on the optional feature.
- Latency: Address applied before edge N appears on PCResult immediately after edge N (1 cycle).
- No enable or stall input: the PC loads every cycle while Reset=0.
- Holding Address constant keeps PCResult constant.
- PCPlus4 = PCResult + 4, truncated to WIDTH bits (wraps modulo 2^WIDTH): 32'hFFFFFFFC -> 32'h00000000.
- Before the first clock edge, PCResult is undefined (X in simulation). The first edge, with or without Reset, establishes a defined value.
- Misaligned is a registered per-load indicator, not sticky. It clears on the next aligned load or on reset.
- All outputs are driven from flops, except PCPlus4 (one adder from the PC flop).

Optional Feature:
- Macro: PC_HOLD_ON_MISALIGN_EN.
- Defined: a misaligned Address is rejected. PCResult holds its previous value and Misaligned <= 1.
- Not defined: a misaligned Address is loaded with bits [1:0] forced to 0 (PCResult <= {Address[WIDTH-1:2],2'b00}) and Misaligned <= 1.
- Aligned loads and reset behave identically in both builds.

Test Plan:
- Reset=1 for 2 edges with Address=32'h00000040 -> PCResult=32'h00000000, PCPlus4=32'h00000004, Misaligned=0.
- Reset=0, Address=32'h00000000 held for 3 edges -> PCResult stays 32'h00000000 every cycle; PCPlus4=32'h00000004.
- Reset=0, Address sequence 32'h00000004, 32'h00000008, 32'h00400020 on consecutive edges -> PCResult follows one cycle later; PCPlus4=32'h00400024 after the last edge.
- PCResult=32'h00000010, then Reset=1 and Address=32'h00000100 on the same edge -> PCResult=32'h00000000 (reset wins); next edge with Reset=0 -> PCResult=32'h00000100.
- Address=32'h00000013 with Reset=0 from PCResult=32'h00000008 -> Misaligned=1. PCResult=32'h00000008 with PC_HOLD_ON_MISALIGN_EN defined, or 32'h00000010 without it. Next aligned load clears Misaligned.
- Address=32'hFFFFFFFC loaded -> PCResult=32'hFFFFFFFC, PCPlus4=32'h00000000.

Source files
------------

// File: rtl/program_counter_if.sv
// Next-PC / PC bus between the next-PC mux side and the PC register.
interface program_counter_if #(
  parameter int unsigned WIDTH = 32
);

  logic [WIDTH-1:0] Address;
  logic [WIDTH-1:0] PCResult;
  logic [WIDTH-1:0] PCPlus4;
  logic             Misaligned;

  // Datapath side: supplies the next address, consumes the PC.
  modport master (
    output Address,
    input  PCResult,
    input  PCPlus4,
    input  Misaligned
  );

  // PC register side.
  modport slave (
    input  Address,
    output PCResult,
    output PCPlus4,
    output Misaligned
  );

endinterface : program_counter_if

// File: rtl/program_counter.sv
// Program counter register for the single-cycle datapath.
// Loads Address every rising edge; synchronous active-high Reset wins over
// any load. A non-word-aligned Address raises Misaligned for that load.
// Build option PC_HOLD_ON_MISALIGN_EN: a misaligned Address is rejected and
// the PC holds; without it the address is loaded with bits [1:0] cleared.
module program_counter #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000)
) (
  input logic             Clk,
  input logic             Reset,
  program_counter_if.slave bus
);

  localparam int unsigned PC_STEP = 4;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic             mis_q;
  logic             mis_d;

  // Next-state selection for the PC and the misalignment flag.
  always_comb begin
    mis_d = |bus.Address[1:0];
    pc_d  = {bus.Address[WIDTH-1:2], 2'b00};
`ifdef PC_HOLD_ON_MISALIGN_EN
    if (mis_d) begin
      pc_d = pc_q;
    end
`endif
  end

  // PC and flag registers; reset is synchronous and has priority.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q  <= RESET_VECTOR;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
    end
  end

  assign bus.PCResult   = pc_q;
  assign bus.Misaligned = mis_q;
  // Sequential-fetch address; wraps modulo 2^WIDTH.
  assign bus.PCPlus4    = pc_q + WIDTH'(PC_STEP);

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter.
module tb_program_counter;

  localparam int unsigned WIDTH = 32;

  logic clk;
  logic reset;
  int   tests;
  int   failures;

  program_counter_if #(.WIDTH(WIDTH)) bus ();

  program_counter #(
    .WIDTH        (WIDTH),
    .RESET_VECTOR (32'h0000_0000)
  ) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.Address = 32'h0000_0040;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (bus.PCResult !== 32'h0000_0000 || bus.PCPlus4 !== 32'h0000_0004 ||
          bus.Misaligned !== 1'b0) begin
        failures++;
        $display("FAIL reset[%0d]: pc=%h p4=%h mis=%b, want pc=00000000 p4=00000004 mis=0",
                 i, bus.PCResult, bus.PCPlus4, bus.Misaligned);
      end
    end
  endtask

  task automatic test_hold();
    reset       = 1'b0;
    bus.Address = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (bus.PCResult !== 32'h0000_0000 || bus.PCPlus4 !== 32'h0000_0004) begin
        failures++;
        $display("FAIL hold[%0d]: pc=%h p4=%h, want pc=00000000 p4=00000004",
                 i, bus.PCResult, bus.PCPlus4);
      end
    end
  endtask

  task automatic test_sequence();
    logic [31:0] vec [3];
    vec = '{32'h0000_0004, 32'h0000_0008, 32'h0040_0020};
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.Address = vec[i];
      tick();
      tests++;
      if (bus.PCResult !== vec[i] || bus.Misaligned !== 1'b0) begin
        failures++;
        $display("FAIL seq[%0d]: pc=%h mis=%b, want pc=%h mis=0",
                 i, bus.PCResult, bus.Misaligned, vec[i]);
      end
    end
    tests++;
    if (bus.PCPlus4 !== 32'h0040_0024) begin
      failures++;
      $display("FAIL seq_p4: p4=%h, want 00400024", bus.PCPlus4);
    end
  endtask

  task automatic test_reset_priority();
    reset       = 1'b0;
    bus.Address = 32'h0000_0010;
    tick();
    tests++;
    if (bus.PCResult !== 32'h0000_0010) begin
      failures++;
      $display("FAIL rstpri_load: pc=%h, want 00000010", bus.PCResult);
    end
    reset       = 1'b1;
    bus.Address = 32'h0000_0100;
    tick();
    tests++;
    if (bus.PCResult !== 32'h0000_0000) begin
      failures++;
      $display("FAIL rstpri_reset: pc=%h, want 00000000", bus.PCResult);
    end
    reset = 1'b0;
    tick();
    tests++;
    if (bus.PCResult !== 32'h0000_0100) begin
      failures++;
      $display("FAIL rstpri_release: pc=%h, want 00000100", bus.PCResult);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] exp_13;
    logic [31:0] exp_07;
`ifdef PC_HOLD_ON_MISALIGN_EN
    exp_13 = 32'h0000_0008;
    exp_07 = 32'h0000_0008;
`else
    exp_13 = 32'h0000_0010;
    exp_07 = 32'h0000_0004;
`endif
    reset       = 1'b0;
    bus.Address = 32'h0000_0008;
    tick();
    tests++;
    if (bus.PCResult !== 32'h0000_0008 || bus.Misaligned !== 1'b0) begin
      failures++;
      $display("FAIL mis_pre: pc=%h mis=%b, want pc=00000008 mis=0",
               bus.PCResult, bus.Misaligned);
    end
    bus.Address = 32'h0000_0013;
    tick();
    tests++;
    if (bus.PCResult !== exp_13 || bus.Misaligned !== 1'b1) begin
      failures++;
      $display("FAIL mis_13: pc=%h mis=%b, want pc=%h mis=1",
               bus.PCResult, bus.Misaligned, exp_13);
    end
    bus.Address = 32'h0000_0007;
    tick();
    tests++;
    if (bus.PCResult !== exp_07 || bus.Misaligned !== 1'b1) begin
      failures++;
      $display("FAIL mis_07: pc=%h mis=%b, want pc=%h mis=1",
               bus.PCResult, bus.Misaligned, exp_07);
    end
    bus.Address = 32'h0000_0020;
    tick();
    tests++;
    if (bus.PCResult !== 32'h0000_0020 || bus.Misaligned !== 1'b0) begin
      failures++;
      $display("FAIL mis_clear: pc=%h mis=%b, want pc=00000020 mis=0",
               bus.PCResult, bus.Misaligned);
    end
    bus.Address = 32'h0000_0022;
    tick();
    tests++;
    if (bus.Misaligned !== 1'b1) begin
      failures++;
      $display("FAIL mis_22: mis=%b, want 1", bus.Misaligned);
    end
    reset = 1'b1;
    tick();
    tests++;
    if (bus.PCResult !== 32'h0000_0000 || bus.Misaligned !== 1'b0) begin
      failures++;
      $display("FAIL mis_reset: pc=%h mis=%b, want pc=00000000 mis=0",
               bus.PCResult, bus.Misaligned);
    end
    reset = 1'b0;
  endtask

  task automatic test_wrap();
    reset       = 1'b0;
    bus.Address = 32'hFFFF_FFFC;
    tick();
    tests++;
    if (bus.PCResult !== 32'hFFFF_FFFC || bus.PCPlus4 !== 32'h0000_0000) begin
      failures++;
      $display("FAIL wrap: pc=%h p4=%h, want pc=fffffffc p4=00000000",
               bus.PCResult, bus.PCPlus4);
    end
  endtask

  initial begin
    tests       = 0;
    failures    = 0;
    reset       = 1'b1;
    bus.Address = '0;
    test_reset();
    test_hold();
    test_sequence();
    test_reset_priority();
    test_misaligned();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule : tb_program_counter
